// File: rtl/fc_irq_arbiter_if.sv
// Core interrupt handshake and software register port of the FC interrupt
// arbiter. The arbiter uses the slave view. Cores and software use the
// master view.
interface fc_irq_arbiter_if #(
  parameter int NB_IRQ   = 32,
  parameter int ID_WIDTH = $clog2(NB_IRQ)
) ();
  logic                core_irq_req_o;
  logic [ID_WIDTH-1:0] core_irq_id_o;
  logic [NB_IRQ-1:0]   core_irq_x_o;
  logic                core_irq_ack_i;
  logic [ID_WIDTH-1:0] core_irq_ack_id_i;
  logic                reg_req_i;
  logic                reg_we_i;
  logic [3:0]          reg_addr_i;
  logic [31:0]         reg_wdata_i;
  logic [31:0]         reg_rdata_o;

  modport slave (
    output core_irq_req_o, core_irq_id_o, core_irq_x_o, reg_rdata_o,
    input  core_irq_ack_i, core_irq_ack_id_i,
    input  reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i
  );

  modport master (
    input  core_irq_req_o, core_irq_id_o, core_irq_x_o, reg_rdata_o,
    output core_irq_ack_i, core_irq_ack_id_i,
    output reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i
  );
endinterface

// File: rtl/fc_irq_arbiter.sv
// Fixed-priority interrupt arbiter for the fabric controller. Edge-captured
// interrupt lines and an event-ID FIFO feed a masked pending vector. The
// highest pending index is presented to the core. Software reaches mask,
// pending and FIFO state through a single-cycle register port.
module fc_irq_arbiter #(
  parameter int NB_IRQ         = 32,
  parameter int ID_WIDTH       = $clog2(NB_IRQ),
  parameter int EVENT_ID_WIDTH = 8,
  parameter int EVT_FIFO_DEPTH = 4,
  parameter int EVT_IRQ_LINE   = 26
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_IRQ-1:0]         irq_i,
  input  logic                      event_fifo_valid_i,
  input  logic [EVENT_ID_WIDTH-1:0] event_fifo_data_i,
  output logic                      event_fifo_fulln_o,
  fc_irq_arbiter_if.slave           bus
);

  localparam int PTR_W = $clog2(EVT_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [NB_IRQ-1:0] EVT_BIT = {{(NB_IRQ-1){1'b0}}, 1'b1} << EVT_IRQ_LINE;

  logic [NB_IRQ-1:0]         r_irq_q;
  logic [NB_IRQ-1:0]         r_pend;
  logic [NB_IRQ-1:0]         r_mask;
  logic                      r_req;
  logic [ID_WIDTH-1:0]       r_id;
  logic [31:0]               r_rdata;
  logic [EVENT_ID_WIDTH-1:0] r_fifo [EVT_FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_count;

  logic                w_rd;
  logic                w_wr;
  logic [1:0]          w_sel;
  logic                w_fifo_nempty;
  logic                w_fifo_full;
  logic                w_push;
  logic                w_pop;
  logic [NB_IRQ-1:0]   w_pending;
  logic [NB_IRQ-1:0]   w_cand;
  logic [ID_WIDTH-1:0] w_win_id;
  logic [NB_IRQ-1:0]   w_ack_clr;
  logic [NB_IRQ-1:0]   w_set;
  logic [NB_IRQ-1:0]   w_clr;
  logic [NB_IRQ-1:0]   w_pend_next;
  logic [31:0]         w_rdata_next;
  logic [NB_IRQ-1:0]   w_irq_x;
  logic                w_unused;

  assign w_rd          = bus.reg_req_i & ~bus.reg_we_i;
  assign w_wr          = bus.reg_req_i & bus.reg_we_i;
  assign w_sel         = bus.reg_addr_i[3:2];
  assign w_fifo_nempty = (r_count != '0);
  assign w_fifo_full   = (r_count == CNT_W'(EVT_FIFO_DEPTH));
  assign w_push        = event_fifo_valid_i & ~w_fifo_full;
  assign w_pop         = w_rd & (w_sel == 2'd3) & w_fifo_nempty;
  assign w_unused      = &{1'b0, bus.reg_addr_i[1:0]};

  // The event line is owned by the FIFO: it mirrors non-empty, never the stored bit
  always_comb begin
    w_pending = r_pend;
    w_pending[EVT_IRQ_LINE] = w_fifo_nempty;
  end

  assign w_cand = w_pending & r_mask;

  // Ascending scan so the highest candidate index is the last one written
  always_comb begin
    w_win_id = '0;
    for (int i = 0; i < NB_IRQ; i++) begin
      if (w_cand[i]) w_win_id = ID_WIDTH'(i);
    end
  end

  // Decode the acknowledged ID, ignoring IDs beyond the implemented lines
  always_comb begin
    w_ack_clr = '0;
    if (bus.core_irq_ack_i && (32'(bus.core_irq_ack_id_i) < NB_IRQ)) begin
      w_ack_clr[bus.core_irq_ack_id_i] = 1'b1;
    end
  end

  // Set sources are applied after clears so a same-cycle set always survives
  always_comb begin
    w_set = irq_i & ~r_irq_q;
    w_clr = w_ack_clr;
    if (w_wr && (w_sel == 2'd1)) w_set = w_set | reg_wdata_slice();
    if (w_wr && (w_sel == 2'd2)) w_clr = w_clr | reg_wdata_slice();
    w_pend_next = ((r_pend & ~w_clr) | w_set) & ~EVT_BIT;
  end

  function automatic logic [NB_IRQ-1:0] reg_wdata_slice();
    return bus.reg_wdata_i[NB_IRQ-1:0];
  endfunction

  // Register read mux; unused upper bits and non-read cycles return zero
  always_comb begin
    w_rdata_next = '0;
    if (w_rd) begin
      case (w_sel)
        2'd0: w_rdata_next[NB_IRQ-1:0] = r_mask;
        2'd1: w_rdata_next[NB_IRQ-1:0] = w_pending;
        2'd2: w_rdata_next = '0;
        default: begin
          if (w_fifo_nempty) begin
            w_rdata_next[31] = 1'b1;
            w_rdata_next[EVENT_ID_WIDTH-1:0] = r_fifo[r_rd_ptr];
          end
        end
      endcase
    end
  end

  // Capture, pending, mask and arbitration state; an ack blanks the request for one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_q <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_req   <= 1'b0;
      r_id    <= '0;
      r_rdata <= '0;
    end else begin
      r_irq_q <= irq_i;
      r_pend  <= w_pend_next;
      if (w_wr && (w_sel == 2'd0)) r_mask <= reg_wdata_slice();
      r_req   <= bus.core_irq_ack_i ? 1'b0 : (|w_cand);
      r_id    <= w_win_id;
      r_rdata <= w_rdata_next;
    end
  end

  // Event FIFO; pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= event_fifo_data_i;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-hot view of the registered request for cores that read raw lines
  always_comb begin
    w_irq_x = '0;
    if (r_req) w_irq_x[r_id] = 1'b1;
  end

  assign bus.core_irq_req_o = r_req;
  assign bus.core_irq_id_o  = r_id;
  assign bus.core_irq_x_o   = w_irq_x;
  assign bus.reg_rdata_o    = r_rdata;
  assign event_fifo_fulln_o = ~w_fifo_full;

endmodule

// File: tb/tb_fc_irq_arbiter.sv
// Self-checking bench for fc_irq_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.
module tb_fc_irq_arbiter;
  localparam int NB_IRQ   = 32;
  localparam int ID_WIDTH = 5;
  localparam int EW       = 8;
  localparam int DEPTH    = 4;
  localparam int EVT      = 26;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   irq_i;
  logic          evValid;
  logic [EW-1:0] evData;
  logic          fulln;

  int checks   = 0;
  int failures = 0;

  logic [31:0]   mPend, mMask, mIrqQ, mRdata;
  logic          mReq, mRdCheck;
  logic [4:0]    mId;
  logic [EW-1:0] mFifo [$];

  always #5 clk_i = ~clk_i;

  fc_irq_arbiter_if #(.NB_IRQ(NB_IRQ), .ID_WIDTH(ID_WIDTH)) bus ();

  fc_irq_arbiter #(
    .NB_IRQ(NB_IRQ), .ID_WIDTH(ID_WIDTH), .EVENT_ID_WIDTH(EW),
    .EVT_FIFO_DEPTH(DEPTH), .EVT_IRQ_LINE(EVT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .irq_i(irq_i),
    .event_fifo_valid_i(evValid),
    .event_fifo_data_i(evData),
    .event_fifo_fulln_o(fulln),
    .bus(bus)
  );

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Behavioural reference: advance one clock using the inputs present at the edge
  task automatic stepModel();
    logic [31:0] curPend, cand, setV, clrV;
    bit canPush;
    if (rst_i) begin
      mPend = '0; mMask = '0; mIrqQ = '0; mFifo.delete();
      mReq = 1'b0; mId = '0; mRdata = '0; mRdCheck = 1'b1;
      return;
    end
    curPend = mPend;
    curPend[EVT] = (mFifo.size() != 0);
    cand = curPend & mMask;
    mReq = bus.core_irq_ack_i ? 1'b0 : (cand != 0);
    mId = '0;
    for (int i = NB_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        mId = 5'(i);
        break;
      end
    end
    canPush = (mFifo.size() < DEPTH);
    mRdCheck = bus.reg_req_i && !bus.reg_we_i;
    mRdata = '0;
    if (mRdCheck) begin
      case (bus.reg_addr_i[3:2])
        2'd0: mRdata = mMask;
        2'd1: mRdata = curPend;
        2'd2: mRdata = '0;
        default: if (mFifo.size() != 0) mRdata = {1'b1, 23'b0, mFifo.pop_front()};
      endcase
    end
    if (evValid && canPush) mFifo.push_back(evData);
    setV = irq_i & ~mIrqQ;
    clrV = '0;
    if (bus.core_irq_ack_i) clrV[bus.core_irq_ack_id_i] = 1'b1;
    if (bus.reg_req_i && bus.reg_we_i) begin
      case (bus.reg_addr_i[3:2])
        2'd0: mMask = bus.reg_wdata_i;
        2'd1: setV = setV | bus.reg_wdata_i;
        2'd2: clrV = clrV | bus.reg_wdata_i;
        default: ;
      endcase
    end
    mPend = (mPend & ~clrV) | setV;
    mPend[EVT] = 1'b0;
    mIrqQ = irq_i;
  endtask

  // Clock the currently driven inputs through one edge and compare every output
  task automatic applyStimulus();
    @(posedge clk_i);
    stepModel();
    #1;
    checkOutput("req", 32'(bus.core_irq_req_o), 32'(mReq));
    checkOutput("id", 32'(bus.core_irq_id_o), 32'(mId));
    checkOutput("irq_x", bus.core_irq_x_o, mReq ? (32'h1 << mId) : 32'h0);
    checkOutput("fulln", 32'(fulln), 32'(mFifo.size() < DEPTH));
    if (mRdCheck) checkOutput("rdata", bus.reg_rdata_o, mRdata);
  endtask

  task automatic regAccess(input logic we, input logic [3:0] addr, input logic [31:0] data);
    bus.reg_req_i = 1'b1; bus.reg_we_i = we; bus.reg_addr_i = addr; bus.reg_wdata_i = data;
    applyStimulus();
    bus.reg_req_i = 1'b0; bus.reg_we_i = 1'b0;
  endtask

  task automatic ackIrq(input logic [4:0] id);
    bus.core_irq_ack_i = 1'b1; bus.core_irq_ack_id_i = id;
    applyStimulus();
    bus.core_irq_ack_i = 1'b0;
  endtask

  task automatic pulseIrq(input logic [31:0] lines);
    irq_i = lines;
    applyStimulus();
    irq_i = '0;
  endtask

  task automatic pushEvent(input logic [EW-1:0] d);
    evValid = 1'b1; evData = d;
    applyStimulus();
    evValid = 1'b0;
  endtask

  task automatic checkFifoReads(input string tag, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      regAccess(1'b0, 4'hC, '0);
      checkOutput(tag, bus.reg_rdata_o, 32'h8000_0000 | 32'(first + k));
    end
  endtask

  initial begin
    rst_i = 1'b1; irq_i = '0; evValid = 1'b0; evData = '0;
    bus.core_irq_ack_i = 1'b0; bus.core_irq_ack_id_i = '0;
    bus.reg_req_i = 1'b0; bus.reg_we_i = 1'b0; bus.reg_addr_i = '0; bus.reg_wdata_i = '0;

    // Reset with toggling interrupt lines
    for (int c = 0; c < 3; c++) begin
      irq_i = $urandom;
      applyStimulus();
    end
    checkOutput("rst_req", 32'(bus.core_irq_req_o), 32'h0);
    checkOutput("rst_id", 32'(bus.core_irq_id_o), 32'h0);
    checkOutput("rst_x", bus.core_irq_x_o, 32'h0);
    checkOutput("rst_fulln", 32'(fulln), 32'h1);
    checkOutput("rst_rdata", bus.reg_rdata_o, 32'h0);
    rst_i = 1'b0; irq_i = '0;
    applyStimulus();
    regAccess(1'b0, 4'h4, '0);
    checkOutput("rst_pend", bus.reg_rdata_o, 32'h0);

    // Priority between two simultaneous edges
    regAccess(1'b1, 4'h0, 32'hFFFF_FFFF);
    pulseIrq((32'h1 << 3) | (32'h1 << 17));
    applyStimulus();
    checkOutput("prio_req", 32'(bus.core_irq_req_o), 32'h1);
    checkOutput("prio_id17", 32'(bus.core_irq_id_o), 32'd17);
    ackIrq(5'd17);
    checkOutput("prio_gap", 32'(bus.core_irq_req_o), 32'h0);
    applyStimulus();
    checkOutput("prio_id3", 32'(bus.core_irq_id_o), 32'd3);
    ackIrq(5'd3);
    applyStimulus();
    checkOutput("prio_done", 32'(bus.core_irq_req_o), 32'h0);
    regAccess(1'b0, 4'h4, '0);
    checkOutput("prio_pend", bus.reg_rdata_o, 32'h0);

    // One-hot view
    pulseIrq(32'h1 << 12);
    applyStimulus();
    checkOutput("x_id12", bus.core_irq_x_o, 32'h0000_1000);
    ackIrq(5'd12);
    checkOutput("x_gap", bus.core_irq_x_o, 32'h0);
    applyStimulus();

    // Masking
    regAccess(1'b1, 4'h0, 32'h0);
    pulseIrq(32'h1 << 5);
    applyStimulus();
    regAccess(1'b0, 4'h4, '0);
    checkOutput("mask_pend", bus.reg_rdata_o, 32'h20);
    checkOutput("mask_noreq", 32'(bus.core_irq_req_o), 32'h0);
    regAccess(1'b1, 4'h0, 32'h20);
    applyStimulus();
    checkOutput("mask_req", 32'(bus.core_irq_req_o), 32'h1);
    checkOutput("mask_id5", 32'(bus.core_irq_id_o), 32'd5);
    ackIrq(5'd5);
    applyStimulus();

    // Set wins over ack on the same bit
    regAccess(1'b1, 4'h0, 32'h200);
    pulseIrq(32'h1 << 9);
    applyStimulus();
    irq_i = 32'h1 << 9;
    ackIrq(5'd9);
    irq_i = '0;
    checkOutput("coll_gap", 32'(bus.core_irq_req_o), 32'h0);
    applyStimulus();
    checkOutput("coll_req", 32'(bus.core_irq_req_o), 32'h1);
    checkOutput("coll_id9", 32'(bus.core_irq_id_o), 32'd9);
    ackIrq(5'd9);
    applyStimulus();

    // FIFO full, drain and pointer wrap
    regAccess(1'b1, 4'h0, 32'h1 << EVT);
    for (int k = 0; k < 5; k++) begin
      pushEvent(8'(8'h11 + k));
      if (k == 3) checkOutput("fifo_full", 32'(fulln), 32'h0);
    end
    checkOutput("fifo_evt_id", 32'(bus.core_irq_id_o), 32'(EVT));
    checkFifoReads("fifo_pop", 32'h11, 4);
    regAccess(1'b0, 4'hC, '0);
    checkOutput("fifo_empty_pop", bus.reg_rdata_o, 32'h0);
    regAccess(1'b0, 4'h4, '0);
    checkOutput("fifo_evt_low", 32'(bus.reg_rdata_o[EVT]), 32'h0);
    for (int k = 0; k < 3; k++) pushEvent(8'(8'h21 + k));
    checkFifoReads("wrap_pop_a", 32'h21, 2);
    for (int k = 0; k < 3; k++) pushEvent(8'(8'h24 + k));
    checkOutput("wrap_full", 32'(fulln), 32'h0);
    checkFifoReads("wrap_pop_b", 32'h23, 4);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic lastAck;
      lastAck = bus.core_irq_ack_i;
      rst_i = ($urandom_range(0, 499) == 0);
      irq_i = irq_i ^ ($urandom & $urandom & $urandom & $urandom);
      bus.core_irq_ack_i = 1'b0;
      if (!lastAck && mReq && $urandom_range(0, 3) == 0) begin
        bus.core_irq_ack_i = 1'b1; bus.core_irq_ack_id_i = mId;
      end else if (!lastAck && $urandom_range(0, 19) == 0) begin
        bus.core_irq_ack_i = 1'b1; bus.core_irq_ack_id_i = 5'($urandom_range(0, 31));
      end
      bus.reg_req_i = ($urandom_range(0, 3) == 0);
      bus.reg_we_i = 1'($urandom);
      bus.reg_addr_i = 4'($urandom);
      bus.reg_wdata_i = $urandom;
      evValid = ($urandom_range(0, 2) == 0);
      evData = 8'($urandom);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
